// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    // Frame receive states
    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } ps2_state_e;

    // rdata_o bit positions
    localparam int unsigned ValidBit = 8;
    localparam int unsigned OvfBit   = 9;
    localparam int unsigned ErrBit   = 10;

    // wdata_i command bits
    localparam int unsigned CmdPopBit = 0;
    localparam int unsigned CmdClrBit = 1;

    // True when data plus parity bit hold an odd number of ones
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Small synchronous FIFO for received scan codes. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module ps2_fifo #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(FIFO_DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Pointer and occupancy tracking; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CntW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Storage array, no reset needed since reads of an empty FIFO are masked upstream
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: synchronizes and filters the bus, decodes
// 11-bit frames, and queues good scan codes behind a 32-bit status/data word.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    input  logic        we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]       clk_sync_q, data_sync_q;
    logic             clk_s, data_s;
    logic             filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             filt_flip, sample_evt;

    ps2_state_e       state_q, state_d;
    logic [7:0]       shift_q;
    logic [2:0]       bit_cnt_q;
    logic             par_ok_q;
    logic [TmoW-1:0]  tmo_cnt_q;
    logic             tmo_hit;

    logic             frame_push, frame_bad;
    logic             cmd_pop, cmd_clr;
    logic             ovf_q, err_q;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;
    logic             unused_wdata;

    assign clk_s        = clk_sync_q[1];
    assign data_s       = data_sync_q[1];
    assign cmd_pop      = we_i && wdata_i[CmdPopBit];
    assign cmd_clr      = we_i && wdata_i[CmdClrBit];
    assign unused_wdata = ^wdata_i[31:2];

    // Level flips on the FILTER_LEN-th consecutive sample that differs from it
    assign filt_flip  = (clk_s != filt_q) && (filt_cnt_q == FiltW'(FILTER_LEN - 1));
    assign sample_evt = filt_flip && filt_q;

    // Input synchronizers and glitch filter on the PS/2 clock
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
            if (clk_s == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_flip) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FiltW'(1);
            end
        end
    end

    // Mid-frame inactivity watchdog
    assign tmo_hit = (state_q != StIdle) && !sample_evt &&
                     (tmo_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

    // Watchdog counter, restarted by every sample event
    always_ff @(posedge clk_i) begin
        if (rst_i || (state_q == StIdle) || sample_evt || tmo_hit) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = StIdle;
        end else if (sample_evt) begin
            case (state_q)
                StIdle:   if (!data_s) state_d = StData;
                StData:   if (bit_cnt_q == 3'd7) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // FSM outputs: accept or reject the frame on the stop-bit sample
    always_comb begin
        frame_push = 1'b0;
        frame_bad  = 1'b0;
        if (sample_evt && (state_q == StStop)) begin
            if (data_s && par_ok_q) begin
                frame_push = 1'b1;
            end else begin
                frame_bad = 1'b1;
            end
        end
    end

    // Frame datapath: LSB-first shift register, bit counter, parity result
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_ok_q  <= 1'b0;
        end else if (sample_evt) begin
            case (state_q)
                StIdle: bit_cnt_q <= '0;
                StData: begin
                    shift_q   <= {data_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
                StParity: par_ok_q <= odd_parity_ok(shift_q, data_s);
                default: ;
            endcase
        end
    end

    // Sticky flags; a new event in the clearing cycle keeps the flag set
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            ovf_q <= (frame_push && fifo_full && !cmd_pop) || (ovf_q && !cmd_clr);
            err_q <= frame_bad || (err_q && !cmd_clr);
        end
    end

    ps2_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (frame_push),
        .wdata_i (shift_q),
        .pop_i   (cmd_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Zero-latency status/data word
    always_comb begin
        rdata_o = '0;
        if (!fifo_empty) begin
            rdata_o[7:0] = fifo_head;
        end
        rdata_o[ValidBit] = !fifo_empty;
        rdata_o[OvfBit]   = ovf_q;
        rdata_o[ErrBit]   = err_q;
    end

    assign irq_o = !fifo_empty;

endmodule

// File: tb/tb_ps2_receiver.sv
// Scoreboard bench for ps2_receiver: frames are bit-banged on the PS/2 lines,
// expected codes and flags are tracked in a queue model and compared on pops.
module tb_ps2_receiver;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FILT  = 8;
    localparam int unsigned TMO   = 300;
    localparam int unsigned HALF  = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic       m_ovf = 1'b0;
    logic       m_err = 1'b0;

    always #5 clk = ~clk;

    ps2_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .FILTER_LEN     (FILT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ps2_clk_i  (ps2_clk),
        .ps2_data_i (ps2_data),
        .we_i       (we),
        .wdata_i    (wdata),
        .rdata_o    (rdata),
        .irq_o      (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word();
        logic [31:0] w;
        w = '0;
        if (exp_q.size() > 0) begin
            w[7:0] = exp_q[0];
            w[8]   = 1'b1;
        end
        w[9]  = m_ovf;
        w[10] = m_err;
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_rdata"}, rdata, exp_word());
        check({tag, "_irq"}, {31'b0, irq}, {31'b0, exp_q.size() > 0});
    endtask

    // Compare head against scoreboard right before it is popped
    task automatic model_cmd_pre(input logic [31:0] cmd);
        if (cmd[0] && exp_q.size() > 0) begin
            check("pop_head", {24'b0, rdata[7:0]}, {24'b0, exp_q[0]});
            void'(exp_q.pop_front());
        end
        if (cmd[1]) begin
            m_ovf = 1'b0;
            m_err = 1'b0;
        end
    endtask

    task automatic write_cmd(input logic [31:0] cmd);
        @(posedge clk);
        #1;
        model_cmd_pre(cmd);
        we    = 1'b1;
        wdata = cmd;
        @(posedge clk);
        #1;
        we    = 1'b0;
        wdata = '0;
    endtask

    // Sends the first nbits of a frame; cmd_at_stop is written on the acceptance cycle
    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input logic [31:0] cmd_at_stop, input int nbits);
        logic [10:0] frame;
        frame = {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk);
            #1 ps2_data = frame[i];
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b0;
            if (i == 10 && cmd_at_stop != '0) begin
                // 2 sync flops + FILT filter samples after the falling edge
                repeat (FILT + 1) @(posedge clk);
                #1;
                model_cmd_pre(cmd_at_stop);
                we    = 1'b1;
                wdata = cmd_at_stop;
                @(posedge clk);
                #1;
                we    = 1'b0;
                wdata = '0;
            end
            repeat (HALF) @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (HALF) @(posedge clk);
        end
        ps2_data = 1'b1;
        if (nbits == 11) begin
            if (!bad_par && !bad_stop) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(code);
                else m_ovf = 1'b1;
            end else begin
                m_err = 1'b1;
            end
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("reset");

        // Good frame then pop
        send_frame(8'h1C, 0, 0, '0, 11);
        check("good_1c", rdata, 32'h0000_011C);
        check_outputs("good_1c");
        write_cmd(32'h1);
        check_outputs("pop_1c");

        // Pop while empty is ignored
        write_cmd(32'h1);
        check_outputs("pop_empty");

        // Bad parity sets frame_err, clear resets it
        send_frame(8'h1C, 1, 0, '0, 11);
        check("bad_par", rdata, 32'h0000_0400);
        write_cmd(32'h2);
        check_outputs("clr_err");

        // Bad stop bit also rejects
        send_frame(8'h7E, 0, 1, '0, 11);
        check_outputs("bad_stop");
        write_cmd(32'h2);

        // Overflow: five frames into a four-deep FIFO
        for (int c = 1; c <= 5; c++) send_frame(8'(c), 0, 0, '0, 11);
        check("ovf_word", rdata, 32'h0000_0301);
        check_outputs("ovf");
        for (int k = 0; k < 4; k++) begin
            write_cmd(32'h1);
            check_outputs("drain");
        end
        write_cmd(32'h2);
        check_outputs("clr_ovf");

        // Full FIFO with pop on the acceptance cycle: no overflow
        for (int c = 0; c < 4; c++) send_frame(8'h10 + 8'(c), 0, 0, '0, 11);
        send_frame(8'hAA, 0, 0, 32'h1, 11);
        check_outputs("push_pop_full");
        for (int k = 0; k < 4; k++) begin
            write_cmd(32'h1);
            check_outputs("drain_aa");
        end

        // Clear coinciding with a new error: the error wins
        send_frame(8'h55, 1, 0, 32'h2, 11);
        check("clr_vs_err", rdata, 32'h0000_0400);
        write_cmd(32'h2);
        check_outputs("clr_after");

        // Timeout after start plus 4 data bits
        send_frame(8'h0F, 0, 0, '0, 5);
        repeat (TMO + 20) @(posedge clk);
        #1;
        check_outputs("timeout");
        send_frame(8'h5A, 0, 0, '0, 11);
        check("after_tmo", rdata, 32'h0000_015A);
        write_cmd(32'h1);
        check_outputs("pop_5a");

        // Reset after 6 data bits, then a clean frame
        send_frame(8'hC3, 0, 0, '0, 7);
        pulse_reset();
        #1;
        check("mid_rst", rdata, 32'h0);
        check_outputs("mid_rst");
        send_frame(8'h33, 0, 0, '0, 11);
        check("after_rst", rdata, 32'h0000_0133);
        check_outputs("after_rst");
        write_cmd(32'h1);
        check_outputs("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
